avl_acc_master: RTL

- Avalon-MM initiator that drives the CORDIC accumulator slave from hardware instead of from the Nios.
- Per job it:
  - clears the accumulator (write 0 to address 1);
  - streams N single-precision samples to address 0 from an internal FIFO;
  - reads the result from address 1, honouring waitrequest;
  - presents the result on a one-cycle valid pulse.
- Sits between a sample-producing datapath and the accelerator's Avalon slave port.

---
 rtl/avl_acc_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/avl_acc_master.sv
// Avalon-MM initiator for the accumulator slave: clear, stream N buffered samples, read the sum back.
// Define AVL_ACC_TIMEOUT_EN to add a waitrequest watchdog that aborts a stalled job and pulses err.
module avl_acc_master #(
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              err,
  output logic              avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, READ} state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
  logic [AW:0]       fcnt, fcnt_nx;
  logic [CNT_W-1:0]  count, accepted, written;
  logic [CNT_W-1:0]  written_inc, count_nx, accepted_nx;
  logic              push, pop, wr_done, rd_done, start_go, timeout_hit;

  always_comb begin
    push        = s_valid && s_ready;
    wr_done     = avm_write && !avm_waitrequest;
    rd_done     = avm_read && !avm_waitrequest;
    pop         = (state == STREAM) && wr_done;
    start_go    = (state == IDLE) && start && !busy;
    rd_ptr_inc  = rd_ptr + AW'(1);
    written_inc = written + CNT_W'(1);
    fcnt_nx     = fcnt + (AW+1)'(push) - (AW+1)'(pop);
    count_nx    = start_go ? num_samples : count;
    accepted_nx = start_go ? '0 : accepted + CNT_W'(push);
  end

  // Sample storage has no reset so it maps onto plain RAM; the pointers carry the state.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= s_data;
  end

`ifdef AVL_ACC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;
  logic            stalled;

  always_comb stalled = (avm_write || avm_read) && avm_waitrequest;

  always_ff @(posedge clk) begin
    if (reset || !stalled)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  always_comb timeout_hit = stalled && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  always_comb timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      accepted      <= '0;
      written       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fcnt          <= '0;
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      err           <= 1'b0;
      avm_address   <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err       <= 1'b0;
      count     <= count_nx;
      accepted  <= accepted_nx;
      fcnt      <= fcnt_nx;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr_inc;
      // Intake closes once the job's samples are all accepted or the buffer is about to be full.
      s_ready <= (accepted_nx < count_nx) && (fcnt_nx < (AW+1)'(FIFO_DEPTH));

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start_go) begin
            state         <= CLEAR;
            busy          <= 1'b1;
            written       <= '0;
            avm_write     <= 1'b1;
            avm_address   <= 1'b1;
            avm_writedata <= '0;
          end
        end
        CLEAR: begin
          if (wr_done) begin
            if (count != '0) begin
              state         <= STREAM;
              avm_address   <= 1'b0;
              avm_write     <= (fcnt != '0);
              avm_writedata <= fifo_mem[rd_ptr];
            end else begin
              state       <= READ;
              avm_write   <= 1'b0;
              avm_read    <= 1'b1;
              avm_address <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (avm_write) begin
            if (wr_done) begin
              written <= written_inc;
              if (written_inc == count) begin
                state       <= READ;
                avm_write   <= 1'b0;
                avm_read    <= 1'b1;
                avm_address <= 1'b1;
              end else begin
                // Present the entry behind the one being popped for back-to-back writes.
                avm_write     <= (fcnt > (AW+1)'(1));
                avm_writedata <= fifo_mem[rd_ptr_inc];
              end
            end
          end else if (fcnt != '0) begin
            avm_write     <= 1'b1;
            avm_writedata <= fifo_mem[rd_ptr];
          end
        end
        READ: begin
          if (rd_done) begin
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            res_data    <= avm_readdata;
            res_valid   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (timeout_hit) begin
        state     <= IDLE;
        busy      <= 1'b0;
        err       <= 1'b1;
        avm_write <= 1'b0;
        avm_read  <= 1'b0;
        s_ready   <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fcnt      <= '0;
      end
    end
  end

endmodule
